sdram_arbiter: RTL and testbench

- Shares the single SDRAM controller (25-bit address, rd/wr edge-triggered, word/byte select, busy handshake) between NPORTS independent requesters, e.g. CPU ROM/WRAM, SPC ARAM, BSRAM/DMA.
- Sits between the core memory clients and the SDRAM controller.
- Serialises requests with fixed priority plus starvation promotion, generates clean rd/wr rising edges, tracks controller busy, and returns read data with a one-cycle ack per port.

---
 rtl/sdram_arbiter.sv | 124 ++++++++++++
 tb/tb_sdram_arbiter.sv | 264 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/sdram_arbiter.sv
// Fixed-priority SDRAM client arbiter with starvation promotion; one access in flight.
// Latency req->ack is 4 cycles plus controller busy time; clients hold req until their ack pulse.
module sdram_arbiter #(
    parameter int NPORTS       = 3,
    parameter int STARVE_LIMIT = 8
) (
    input  logic                 clk,
    input  logic                 init_n,
    input  logic [NPORTS-1:0]    req,
    input  logic [NPORTS-1:0]    we,
    input  logic [NPORTS-1:0]    word,
    input  logic [NPORTS*25-1:0] addr,
    input  logic [NPORTS*16-1:0] wdata,
    output logic [NPORTS-1:0]    ack,
    output logic [15:0]          rdata,
    output logic [1:0]           grant,
    output logic                 active,
    output logic [24:0]          mem_addr,
    output logic                 mem_rd,
    output logic                 mem_wr,
    output logic                 mem_word,
    output logic [15:0]          mem_din,
    input  logic [15:0]          mem_dout,
    input  logic                 mem_busy
);

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} state_t;

    localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

    state_t     state;
    logic [3:0] starve_cnt [NPORTS];
    logic       cur_we;
    logic [1:0] win;
    logic [1:0] norm_idx;
    logic [1:0] force_idx;
    logic       force_vld;

    // Descending scan so the lowest index wins in both the forced and normal pick.
    always_comb begin
        norm_idx  = '0;
        force_idx = '0;
        force_vld = 1'b0;
        for (int i = NPORTS - 1; i >= 0; i--) begin
            if (req[i]) begin
                norm_idx = 2'(i);
            end
            if (req[i] && (starve_cnt[i] >= LIMIT)) begin
                force_idx = 2'(i);
                force_vld = 1'b1;
            end
        end
        win = force_vld ? force_idx : norm_idx;
    end

    always_ff @(posedge clk or negedge init_n) begin
        if (!init_n) begin
            state    <= IDLE;
            ack      <= '0;
            rdata    <= '0;
            grant    <= '0;
            active   <= 1'b0;
            mem_addr <= '0;
            mem_rd   <= 1'b0;
            mem_wr   <= 1'b0;
            mem_word <= 1'b0;
            mem_din  <= '0;
            cur_we   <= 1'b0;
            for (int i = 0; i < NPORTS; i++) begin
                starve_cnt[i] <= '0;
            end
        end else begin
            ack <= '0;
            case (state)
                IDLE: begin
                    if (|req) begin
                        grant    <= win;
                        active   <= 1'b1;
                        mem_addr <= addr[int'(win)*25 +: 25];
                        mem_din  <= wdata[int'(win)*16 +: 16];
                        mem_word <= word[win];
                        cur_we   <= we[win];
                        mem_rd   <= ~we[win];
                        mem_wr   <= we[win];
                        state    <= ISSUE;
                        for (int i = 0; i < NPORTS; i++) begin
                            if (2'(i) == win) begin
                                starve_cnt[i] <= '0;
                            end else if (req[i]) begin
                                starve_cnt[i] <= (starve_cnt[i] >= LIMIT) ? LIMIT
                                                                          : starve_cnt[i] + 4'd1;
                            end else begin
                                starve_cnt[i] <= '0;
                            end
                        end
                    end
                end
                // Controller may sit in init with busy low indefinitely; keep the strobe up.
                ISSUE: begin
                    if (mem_busy) begin
                        mem_rd <= 1'b0;
                        mem_wr <= 1'b0;
                        state  <= WAIT;
                    end
                end
                WAIT: begin
                    if (!mem_busy) begin
                        if (!cur_we) begin
                            rdata <= mem_dout;
                        end
                        ack[grant] <= 1'b1;
                        state      <= DONE;
                    end
                end
                DONE: begin
                    active <= 1'b0;
                    state  <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_sdram_arbiter.sv
// Directed bench for sdram_arbiter with a behavioural controller model and in-order scoreboard.
module tb_sdram_arbiter;
    localparam int NP = 3;
    localparam int SL = 8;

    typedef struct {
        int          port;
        logic [24:0] addr;
        logic        we;
        logic        word;
        logic [15:0] wdata;
        logic [15:0] rdata;
    } exp_t;

    logic             clk = 1'b0;
    logic             init_n;
    logic [NP-1:0]    req, we, word, ack;
    logic [NP*25-1:0] addr;
    logic [NP*16-1:0] wdata;
    logic [15:0]      rdata, mem_din, mem_dout;
    logic [1:0]       grant;
    logic             active, mem_rd, mem_wr, mem_word, mem_busy;
    logic [24:0]      mem_addr;

    int   checks = 0;
    int   errors = 0;
    exp_t exp_q[$];
    int   pre_delay, busy_len, mdl_pend, mdl_bcnt;
    bit   mdl_on, prev_cmd, sb_en;
    int   low_run, n_edges, arb_n, first_p2, wr_run, last_wr_run;
    int   served[NP];
    int   hold[NP];
    bit   auto_rr[NP];
    logic [15:0] last_rd;

    always #5 clk = ~clk;

    sdram_arbiter #(.NPORTS(NP), .STARVE_LIMIT(SL)) dut (
        .clk(clk), .init_n(init_n), .req(req), .we(we), .word(word), .addr(addr),
        .wdata(wdata), .ack(ack), .rdata(rdata), .grant(grant), .active(active),
        .mem_addr(mem_addr), .mem_rd(mem_rd), .mem_wr(mem_wr), .mem_word(mem_word),
        .mem_din(mem_din), .mem_dout(mem_dout), .mem_busy(mem_busy)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic request(input int p, input logic w, input logic wd, input logic [24:0] a,
                           input logic [15:0] d, input logic [15:0] rv);
        exp_t e;
        we[p]           = w;
        word[p]         = wd;
        addr[p*25 +: 25]  = a;
        wdata[p*16 +: 16] = d;
        req[p]          = 1'b1;
        if (!w) last_rd = rv;
        e.port = p; e.addr = a; e.we = w; e.word = wd; e.wdata = d; e.rdata = last_rd;
        if (sb_en) exp_q.push_back(e);
    endtask

    task automatic on_issue();
        exp_t e;
        chk("issue_expected", 64'(exp_q.size() != 0), 64'd1);
        if (exp_q.size() != 0) begin
            e = exp_q[0];
            chk("issue_grant", 64'(grant), 64'(e.port));
            chk("issue_addr", 64'(mem_addr), 64'(e.addr));
            chk("issue_wr", 64'(mem_wr), 64'(e.we));
            chk("issue_rd", 64'(mem_rd), 64'(!e.we));
            chk("issue_word", 64'(mem_word), 64'(e.word));
            chk("issue_din", 64'(mem_din), 64'(e.wdata));
            chk("issue_active", 64'(active), 64'd1);
            mem_dout = e.we ? 16'hDEAD : e.rdata;
            // Post-grant changes on the winning port must not leak to the controller.
            addr[e.port*25 +: 25]  = ~e.addr;
            wdata[e.port*16 +: 16] = ~e.wdata;
        end
    endtask

    task automatic on_ack();
        exp_t e;
        chk("ack_expected", 64'(exp_q.size() != 0), 64'd1);
        if (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            chk("ack_port", 64'(ack), 64'(1 << e.port));
            chk("ack_rdata", 64'(rdata), 64'(e.rdata));
            chk("ack_addr_held", 64'(mem_addr), 64'(e.addr));
            chk("ack_din_held", 64'(mem_din), 64'(e.wdata));
        end
    endtask

    task automatic step();
        logic cmd;
        @(negedge clk);
        chk("rd_wr_excl", 64'(mem_rd & mem_wr), 64'd0);
        cmd = mem_rd | mem_wr;
        if (cmd && !prev_cmd) begin
            n_edges++;
            arb_n++;
            chk("strobe_gap", 64'(low_run >= 2), 64'd1);
            if (grant == 2'd2 && first_p2 == 0) first_p2 = arb_n;
            if (sb_en) on_issue();
            mdl_on = 1; mdl_pend = pre_delay; mdl_bcnt = busy_len;
        end
        if (mem_wr) wr_run++;
        else begin
            if (wr_run > 0) last_wr_run = wr_run;
            wr_run = 0;
        end
        low_run  = cmd ? 0 : low_run + 1;
        prev_cmd = cmd;
        if (mdl_on) begin
            if (mdl_pend > 0) begin
                mdl_pend--; mem_busy = 1'b0;
            end else if (mdl_bcnt > 0) begin
                mem_busy = 1'b1; mdl_bcnt--;
            end else begin
                mem_busy = 1'b0; mdl_on = 0;
            end
        end
        for (int p = 0; p < NP; p++) begin
            if (hold[p] > 0) begin
                hold[p]--;
                if (hold[p] == 0 && auto_rr[p]) req[p] = 1'b1;
            end
        end
        if (ack != '0) begin
            for (int p = 0; p < NP; p++) begin
                if (ack[p]) begin
                    served[p]++;
                    req[p]  = 1'b0;
                    hold[p] = auto_rr[p] ? 2 : 0;
                end
            end
            if (sb_en) on_ack();
        end
    endtask

    task automatic drain(input string tag);
        int n = 0;
        while (exp_q.size() > 0 && n < 500) begin
            step();
            n++;
        end
        chk({tag, "_timeout"}, 64'(exp_q.size()), 64'd0);
        repeat (3) step();
    endtask

    task automatic wait_busy_phase();
        int n  = 0;
        int e0 = n_edges;
        while ((n_edges == e0 || mem_rd || mem_wr) && n < 200) begin
            step();
            n++;
        end
        chk("wait_phase_timeout", 64'(n < 200), 64'd1);
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_ack"}, 64'(ack), 64'd0);
        chk({tag, "_rd"}, 64'(mem_rd), 64'd0);
        chk({tag, "_wr"}, 64'(mem_wr), 64'd0);
        chk({tag, "_active"}, 64'(active), 64'd0);
        chk({tag, "_grant"}, 64'(grant), 64'd0);
        chk({tag, "_rdata"}, 64'(rdata), 64'd0);
        chk({tag, "_addr"}, 64'(mem_addr), 64'd0);
        chk({tag, "_din"}, 64'(mem_din), 64'd0);
        chk({tag, "_word"}, 64'(mem_word), 64'd0);
    endtask

    initial begin
        int s0, s1, s2, e0, n;
        init_n = 1'b0; req = '0; we = '0; word = '0; addr = '0; wdata = '0;
        mem_dout = '0; mem_busy = 1'b0; sb_en = 1; pre_delay = 0; busy_len = 3;
        mdl_on = 0; prev_cmd = 0; low_run = 0; n_edges = 0; arb_n = 0; first_p2 = 0;
        wr_run = 0; last_wr_run = 0; last_rd = '0;
        for (int p = 0; p < NP; p++) begin
            served[p] = 0; hold[p] = 0; auto_rr[p] = 0;
        end

        repeat (3) step();
        chk_all_zero("reset");
        init_n = 1'b1;
        repeat (2) step();

        // Single read from port 1.
        e0 = n_edges;
        request(1, 1'b0, 1'b1, 25'h0000102, 16'h0000, 16'hBEEF);
        drain("single_rd");
        chk("single_rd_edges", 64'(n_edges - e0), 64'd1);
        chk("single_rd_acks", 64'(served[1]), 64'd1);
        chk("single_rd_rdata", 64'(rdata), 64'hBEEF);

        // Write while the controller is still initialising.
        pre_delay = 50;
        request(0, 1'b1, 1'b1, 25'h1ABCDEF, 16'h1234, 16'h0000);
        drain("init_wr");
        chk("init_wr_hold", 64'(last_wr_run >= 50), 64'd1);
        chk("init_wr_rdata_kept", 64'(rdata), 64'hBEEF);
        pre_delay = 0;

        // Simultaneous requests, including a byte write on port 2.
        s0 = served[0]; s1 = served[1]; s2 = served[2];
        request(0, 1'b0, 1'b1, 25'h0000010, 16'h0000, 16'h1111);
        request(1, 1'b1, 1'b1, 25'h0000020, 16'h2222, 16'h0000);
        request(2, 1'b1, 1'b0, 25'h0000031, 16'h0033, 16'h0000);
        drain("prio");
        chk("prio_acks0", 64'(served[0] - s0), 64'd1);
        chk("prio_acks1", 64'(served[1] - s1), 64'd1);
        chk("prio_acks2", 64'(served[2] - s2), 64'd1);

        // Starvation: ports 0/1 re-request right after each ack, port 2 holds req.
        sb_en = 0; busy_len = 2; arb_n = 0; first_p2 = 0; s2 = served[2];
        auto_rr[0] = 1; auto_rr[1] = 1;
        we = '0; word = '1; req = '1;
        n = 0;
        while (first_p2 == 0 && n < 400) begin
            step();
            n++;
        end
        auto_rr[0] = 0; auto_rr[1] = 0; hold[0] = 0; hold[1] = 0;
        req[0] = 1'b0; req[1] = 1'b0;
        repeat (40) step();
        chk("starve_p2_granted", 64'(first_p2 >= 1 && first_p2 <= SL + 1), 64'd1);
        chk("starve_p2_acks", 64'(served[2] - s2), 64'd1);
        chk("starve_idle", 64'(active), 64'd0);
        sb_en = 1; busy_len = 6;

        // Port 2 withdraws req during WAIT.
        s2 = served[2];
        request(2, 1'b0, 1'b1, 25'h0AA55AA, 16'h0000, 16'h5A5A);
        wait_busy_phase();
        req[2] = 1'b0;
        drain("withdraw");
        chk("withdraw_acks", 64'(served[2] - s2), 64'd1);
        request(1, 1'b1, 1'b1, 25'h0000400, 16'h7777, 16'h0000);
        drain("after_withdraw");

        // Reset during WAIT abandons the access.
        s0 = served[0];
        request(0, 1'b0, 1'b1, 25'h0000800, 16'h0000, 16'h9999);
        wait_busy_phase();
        init_n = 1'b0;
        #1;
        chk_all_zero("midrst");
        exp_q.delete();
        mdl_on = 0; mem_busy = 1'b0; req = '0; last_rd = '0;
        repeat (3) step();
        chk("midrst_no_ack", 64'(served[0] - s0), 64'd0);
        init_n = 1'b1;
        request(0, 1'b0, 1'b1, 25'h0000808, 16'h0000, 16'hC0DE);
        drain("post_rst");
        chk("post_rst_acks", 64'(served[0] - s0), 64'd1);
        chk("post_rst_rdata", 64'(rdata), 64'hC0DE);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
